muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with its own HI/LO register pair, serving the MIPS execute stage in place of single-cycle combinational multiplies. It accepts MULT/MULTU/DIV/DIVU on a start/busy/done handshake, iterates one bit per cycle, and applies sign correction in a final cycle. It also services MTHI/MTLO writes and supports a pipeline-flush cancel. The datapath stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width; legal range ≥ 4.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  operation request; sampled only in IDLE.
- `op`  in  2  operation select: `op[1]` 0 = multiply, 1 = divide; `op[0]` 1 = signed, 0 = unsigned.
- `a`  in  WIDTH  multiplicand or dividend (rs).
- `b`  in  WIDTH  multiplier or divisor (rt).
- `cancel`  in  1  flush request; aborts the current operation.
- `hi_wen`  in  1  MTHI write enable.
- `lo_wen`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

State machine: IDLE, CALC, FIX.
- **IDLE**, on `start=1` and `cancel=0`:
  - Latch `op`.
  - Latch the operand magnitudes: two's-complement absolute value if signed, raw value if unsigned.
  - Latch the sign flags.
  - Load the bit counter with WIDTH.
  - Go to CALC.
- **Divide with `b=0`:** go directly to FIX with a forced result. `hi = a` (raw), `lo` = all ones, with no sign correction.
- **CALC, multiply:** radix-2 shift-add into a 2*WIDTH accumulator, one multiplier bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle, WIDTH-bit remainder and quotient.
- **CALC exit:** the counter decrements each cycle. When the counter reaches 1 and its final iteration completes, go to FIX.
- **FIX:** write the result to `hi`/`lo`, pulse `done`, return to IDLE.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: the quotient is negated if the signs differ. The remainder takes the dividend's sign.
  - Results are truncated mod 2^WIDTH. Example: signed `0x80000000 / 0xFFFFFFFF` gives `lo = 0x80000000`, `hi = 0`.
- **`start` ignored:** while in CALC or FIX.
- **`cancel`:** in CALC or FIX, the next state is IDLE. `hi`/`lo` are unchanged and no `done` pulse is issued. A `cancel` with `start` in IDLE means the start is dropped.
- **MTHI/MTLO:** `hi_wen`/`lo_wen` write `wdata` only when `busy=0`, and are ignored while busy. Both enables may be asserted in the same cycle.
- **`busy`:** high in CALC and FIX.

## Timing

- **Reset:** `rst` high immediately forces IDLE, `busy=0`, `done=0`, `hi=0`, `lo=0`, counter 0. This includes reset asserted mid-operation.
- **Latency (normal):**
  - The `start` acceptance edge is edge 0.
  - CALC occupies edges 1..WIDTH.
  - At edge WIDTH+1, FIX writes `hi`/`lo`, sets `done=1`, and clears `busy`.
  - With WIDTH=32, `done` is high in the cycle after edge 33.
- **Latency (divide by zero):** edge 1 goes to FIX. At edge 2, `hi`/`lo` are written and `done=1`.
- **Outputs:** `busy` and `done` are registered. `done` is high for exactly one cycle. `busy` is high from edge 0 up to the edge that raises `done`.
- **Back-to-back:** a `start` in the cycle where `done=1` is accepted, because the unit is already in IDLE. Throughput is one operation per WIDTH+2 cycles.
- **MT write vs. completion:** an MT write in the cycle the result is written is ignored (still busy). An MT write in the `done` cycle is accepted and overrides the result.
- **Cancel timing:** `cancel` sampled at edge k forces `busy=0` after edge k.

## Test plan

- **Signed multiply:** MULT with `a=0xFFFFFFFE`, `b=3` -> exactly 33 cycles after the start edge, `done` pulses once with `hi=0xFFFFFFFF`, `lo=0xFFFFFFFA`. `busy` is high for the cycles between.
- **Unsigned multiply, then back-to-back divide:** MULTU with the same operands -> `hi=0x00000002`, `lo=0xFFFFFFFA`. Then DIVU 7/2 started in the `done` cycle -> `lo=3`, `hi=1`.
- **Signed divide and overflow case:** DIV -7/2 (`a=0xFFFFFFF9`, `b=2`) -> `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIV `0x80000000 / 0xFFFFFFFF` -> `lo=0x80000000`, `hi=0`.
- **Divide by zero:** DIV with `a=0x1234`, `b=0` -> `done` 2 cycles after start with `hi=0x1234`, `lo=0xFFFFFFFF`.
- **Cancel mid-operation:** preload `hi=0xAAAA`, `lo=0x5555` via `hi_wen`/`lo_wen`. Start MULT and assert `cancel` at CALC cycle 10 -> `busy=0` next cycle, no `done`, `hi`/`lo` unchanged. An MT write attempted while busy is ignored.
- **Reset mid-operation:** assert `rst` asynchronously mid-CALC -> `busy=0`, `done=0`, `hi=lo=0` without waiting for a clock edge. After release, a new MULTU 5*6 gives `lo=30`, `hi=0`.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine with its own HI/LO pair.
// One bit is processed per cycle in CALC. FIX applies sign correction and
// commits the result. MTHI/MTLO writes are serviced whenever the unit is idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t               state;
    logic [1:0]           op_r;        // op[1]: divide, op[0]: signed
    logic                 sign_a;      // dividend / multiplicand was negative
    logic                 sign_b;      // divisor / multiplier was negative
    logic                 div_zero;    // divide by zero, result forced at start
    logic [CW-1:0]        cnt;         // iterations still to run
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {remainder, remaining dividend bits / quotient bits}.
    logic [2*WIDTH-1:0]   acc;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    // Operand magnitudes: absolute value only for signed operations.
    assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

    // One shift-add (multiply) or restoring-subtract (divide) iteration.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        add_sum  = '0;
        trial    = '0;
        step_acc = acc;
        if (!op_r[1]) begin
            add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a & {WIDTH{acc[0]}}};
            step_acc = {add_sum, acc[WIDTH-1:1]};
        end else begin
            // Shifted remainder is WIDTH+1 bits: old remainder plus next dividend bit.
            trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
            if (!trial[WIDTH]) begin
                step_acc = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final sign correction of the unsigned magnitude result.
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (!div_zero && op_r[0]) begin
            if (!op_r[1]) begin
                if (sign_a ^ sign_b) begin
                    {res_hi, res_lo} = -acc;
                end
            end else begin
                if (sign_a ^ sign_b) begin
                    res_lo = -acc[WIDTH-1:0];
                end
                if (sign_a) begin
                    res_hi = -acc[2*WIDTH-1:WIDTH];
                end
            end
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_r     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        op_r     <= op;
                        sign_a   <= op[0] & a[WIDTH-1];
                        sign_b   <= op[0] & b[WIDTH-1];
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        div_zero <= op[1] && (b == '0);
                        cnt      <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= S_CALC;
                        if (op[1] && (b == '0)) begin
                            acc <= {a, {WIDTH{1'b1}}};
                        end else if (op[1]) begin
                            acc <= {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            acc <= {{WIDTH{1'b0}}, abs_b};
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (div_zero) begin
                        state <= S_FIX;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (!cancel) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
            // MTHI/MTLO only while idle; busy is high in FIX so no overlap with the commit.
            if (!busy) begin
                if (hi_wen) begin
                    hi <= wdata;
                end
                if (lo_wen) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit,
// plus sequences for back-to-back issue, MT timing, cancel and async reset.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b11;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hi_wen (hi_wen),
        .lo_wen (lo_wen),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an operation and let the next rising edge accept it.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("done_single_pulse", {63'd0, done}, 64'd0);
    endtask

    // Count edges after the start edge until done; bounded.
    task automatic wait_done(output int n);
        logic busy_ok;
        busy_ok = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("busy_held", {63'd0, busy_ok}, 64'd1);
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_clear_at_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int n;

        vecs[0]  = '{"mult_neg2x3",     OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 33};
        vecs[1]  = '{"multu_fffffffe3", OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 33};
        vecs[2]  = '{"divu_7_2",        OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         33};
        vecs[3]  = '{"div_m7_2",        OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[4]  = '{"div_overflow",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
        vecs[5]  = '{"div_by_zero",     OP_DIV,   32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 2};
        vecs[6]  = '{"mult_7_m5",       OP_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 33};
        vecs[7]  = '{"div_7_m2",        OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
        vecs[8]  = '{"divu_max_16",     OP_DIVU,  32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 33};
        vecs[9]  = '{"multu_max_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[10] = '{"divu_by_zero",    OP_DIVU,  32'h8000_0000, 32'd0,        32'h8000_0000, 32'hFFFF_FFFF, 2};
        vecs[11] = '{"div_neg_by_zero", OP_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 2};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        cancel = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Vectors issued back to back: each start lands in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(n);
            check({vecs[i].name, "_lat"}, 64'(n), 64'(vecs[i].lat));
            check({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            check({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
        end

        // MT write in the commit cycle is ignored; in the done cycle it wins.
        @(negedge clk);
        start_op(OP_MULTU, 32'd5, 32'd6);
        repeat (32) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("fix_still_busy", {63'd0, busy}, 64'd1);
        hi_wen = 1'b1; wdata = 32'h99;
        @(posedge clk);
        @(negedge clk);
        hi_wen = 1'b0;
        check("mt_in_fix_done", {63'd0, done}, 64'd1);
        check("mt_in_fix_ignored", {32'd0, hi}, 64'd0);
        check("mt_in_fix_lo", {32'd0, lo}, 64'd30);
        lo_wen = 1'b1; wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        lo_wen = 1'b0;
        check("mt_in_done_cycle", {32'd0, lo}, 64'h77);

        // Preload HI/LO together, then cancel a multiply in CALC cycle 10.
        hi_wen = 1'b1; lo_wen = 1'b1; wdata = 32'hAAAA;
        @(posedge clk);
        @(negedge clk);
        hi_wen = 1'b0; wdata = 32'h5555;
        @(posedge clk);
        @(negedge clk);
        lo_wen = 1'b0;
        check("preload_hi", {32'd0, hi}, 64'hAAAA);
        check("preload_lo", {32'd0, lo}, 64'h5555);
        start_op(OP_MULT, 32'd3, 32'd4);
        hi_wen = 1'b1; lo_wen = 1'b1; wdata = 32'hDEAD;
        @(posedge clk);
        @(negedge clk);
        hi_wen = 1'b0; lo_wen = 1'b0;
        check("mt_busy_ignored", {hi, lo}, {32'hAAAA, 32'h5555});
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        n = 0;
        repeat (40) begin
            if (done) n++;
            @(posedge clk);
            @(negedge clk);
        end
        check("cancel_no_done", 64'(n), 64'd0);
        check("cancel_hilo", {hi, lo}, {32'hAAAA, 32'h5555});

        // start together with cancel in IDLE is dropped.
        start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_dropped", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-CALC, seen before any clock edge.
        start_op(OP_MULT, 32'd9, 32'd9);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(OP_MULTU, 32'd5, 32'd6);
        wait_done(n);
        check("post_rst_lat", 64'(n), 64'd33);
        check("post_rst_result", {hi, lo}, {32'd0, 32'd30});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
